// File: rtl/fpu_div_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fpu_div_seq                                                              |
// | Iterative IEEE-754 divider z = a / b using restoring division. Config    |
// | macro FPU_DIV_RADIX4_EN selects two quotient bits per cycle.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fpu_div_seq #(
   parameter int e_p = 8,
   parameter int m_p = 23
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             v_i,
   input  logic [e_p+m_p:0] a_i,
   input  logic [e_p+m_p:0] b_i,
   output logic             ready_and_o,
   output logic             v_o,
   output logic [e_p+m_p:0] z_o,
   output logic             unimplemented_o,
   output logic             invalid_o,
   output logic             overflow_o,
   output logic             underflow_o,
   output logic             divide_by_zero_o,
   input  logic             yumi_i
);

   localparam int W  = e_p + m_p + 1;
   localparam int EW = e_p + 2;
   localparam int N  = m_p + 3;
   localparam int RW = m_p + 2;
`ifdef FPU_DIV_RADIX4_EN
   localparam int BPC = 2;
`else
   localparam int BPC = 1;
`endif
   localparam int ITER = (N + BPC - 1) / BPC;
   localparam int QW   = ITER * BPC;
   localparam int CW   = $clog2(ITER + 1);

   localparam logic [CW-1:0]        CNT_INIT = CW'(ITER - 1);
   localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
   localparam logic signed [EW-1:0] BIAS_S   = EW'((1 << (e_p - 1)) - 1);
   localparam logic signed [EW-1:0] EMAX_S   = EW'((1 << e_p) - 1);
   localparam logic signed [EW-1:0] ONE_S    = EW'(1);
   localparam logic signed [EW-1:0] ZERO_S   = '0;
   localparam logic [W-1:0] QNAN = {1'b0, {e_p{1'b1}}, 1'b1, {(m_p-1){1'b0}}};
   localparam logic [W-1:0] SNAN = {1'b0, {e_p{1'b1}}, 2'b01, {(m_p-2){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [RW-1:0]          rem_q, rem_d;
   logic [m_p:0]           div_q, div_d;
   logic [QW-1:0]          quo_q, quo_d;
   logic signed [EW-1:0]   exp_q, exp_d;
   logic                   sign_q, sign_d;
   logic [W-1:0]           z_q, z_d;
   logic                   inv_q, inv_d;
   logic                   dbz_q, dbz_d;
   logic                   ovf_q, ovf_d;
   logic                   unf_q, unf_d;
   logic                   uni_q, uni_d;

   // Operand field decode
   logic             w_sa, w_sb, w_sgn;
   logic [e_p-1:0]   w_ea, w_eb;
   logic [m_p-1:0]   w_ma, w_mb;
   logic             w_a_nan, w_a_snan, w_a_qnan, w_a_inf, w_a_zero, w_a_den;
   logic             w_b_nan, w_b_snan, w_b_qnan, w_b_inf, w_b_zero, w_b_den;

   assign w_sa  = a_i[W-1];
   assign w_sb  = b_i[W-1];
   assign w_sgn = w_sa ^ w_sb;
   assign w_ea  = a_i[W-2 -: e_p];
   assign w_eb  = b_i[W-2 -: e_p];
   assign w_ma  = a_i[m_p-1:0];
   assign w_mb  = b_i[m_p-1:0];

   assign w_a_nan  = (&w_ea) & (|w_ma);
   assign w_a_snan = w_a_nan & ~w_ma[m_p-1];
   assign w_a_qnan = w_a_nan & w_ma[m_p-1];
   assign w_a_inf  = (&w_ea) & ~(|w_ma);
   assign w_a_zero = ~(|w_ea) & ~(|w_ma);
   assign w_a_den  = ~(|w_ea) & (|w_ma);

   assign w_b_nan  = (&w_eb) & (|w_mb);
   assign w_b_snan = w_b_nan & ~w_mb[m_p-1];
   assign w_b_qnan = w_b_nan & w_mb[m_p-1];
   assign w_b_inf  = (&w_eb) & ~(|w_mb);
   assign w_b_zero = ~(|w_eb) & ~(|w_mb);
   assign w_b_den  = ~(|w_eb) & (|w_mb);

   // Special-operand resolution, highest priority first
   logic             w_spec;
   logic [W-1:0]     w_spec_z;
   logic             w_spec_inv, w_spec_dbz, w_spec_uni;

   always_comb begin
      w_spec     = 1'b1;
      w_spec_z   = QNAN;
      w_spec_inv = 1'b0;
      w_spec_dbz = 1'b0;
      w_spec_uni = 1'b0;
      if (w_a_snan | w_b_snan) begin
         w_spec_z   = SNAN;
         w_spec_inv = 1'b1;
      end else if (w_a_qnan | w_b_qnan) begin
         w_spec_z = QNAN;
      end else if ((w_a_inf & w_b_inf) | (w_a_zero & w_b_zero)) begin
         w_spec_z   = QNAN;
         w_spec_inv = 1'b1;
      end else if (w_a_inf) begin
         w_spec_z = {w_sgn, {e_p{1'b1}}, {m_p{1'b0}}};
      end else if (w_b_inf) begin
         w_spec_z = {w_sgn, {(W-1){1'b0}}};
      end else if (w_b_zero) begin
         w_spec_z   = {w_sgn, {e_p{1'b1}}, {m_p{1'b0}}};
         w_spec_dbz = 1'b1;
      end else if (w_a_zero) begin
         w_spec_z = {w_sgn, {(W-1){1'b0}}};
      end else if (w_a_den | w_b_den) begin
         w_spec_z   = QNAN;
         w_spec_uni = 1'b1;
      end else begin
         w_spec = 1'b0;
      end
   end

   // BPC cascaded restoring steps; the first step yields the more significant bit
   logic [RW-1:0]    w_rem_nx;
   logic [QW-1:0]    w_quo_nx;
   logic             w_qbit;

   always_comb begin
      w_rem_nx = rem_q;
      w_quo_nx = quo_q;
      w_qbit   = 1'b0;
      for (int k = 0; k < BPC; k++) begin
         w_qbit = (w_rem_nx >= {1'b0, div_q});
         if (w_qbit) begin
            w_rem_nx = w_rem_nx - {1'b0, div_q};
         end
         w_rem_nx = w_rem_nx << 1;
         w_quo_nx = {w_quo_nx[QW-2:0], w_qbit};
      end
   end

   // Any quotient bits beyond N only ever feed the sticky bit
   logic             w_xtra;
   generate
      if (QW > N) begin : g_xtra_bits
         assign w_xtra = |w_quo_nx[QW-N-1:0];
      end else begin : g_no_xtra
         assign w_xtra = 1'b0;
      end
   endgenerate

   // Normalise, round to nearest even, range check
   logic [N-1:0]           w_qf;
   logic                   w_remnz;
   logic [m_p-1:0]         w_mant;
   logic                   w_guard, w_sticky, w_up;
   logic [m_p:0]           w_mr;
   logic signed [EW-1:0]   w_e, w_er;
   logic                   w_ovf, w_unf;
   logic [W-1:0]           w_res_z;

   assign w_qf    = w_quo_nx[QW-1 -: N];
   assign w_remnz = |w_rem_nx;

   always_comb begin
      if (w_qf[N-1]) begin
         w_mant   = w_qf[N-2:2];
         w_guard  = w_qf[1];
         w_sticky = w_qf[0] | w_remnz | w_xtra;
         w_e      = exp_q;
      end else begin
         w_mant   = w_qf[N-3:1];
         w_guard  = w_qf[0];
         w_sticky = w_remnz | w_xtra;
         w_e      = exp_q - ONE_S;
      end
      w_up = w_guard & (w_sticky | w_mant[0]);
      w_mr = {1'b0, w_mant} + {{m_p{1'b0}}, w_up};
      w_er = w_mr[m_p] ? (w_e + ONE_S) : w_e;
      w_ovf = (w_er >= EMAX_S);
      w_unf = (w_er <= ZERO_S);
      if (w_ovf) begin
         w_res_z = {sign_q, {e_p{1'b1}}, {m_p{1'b0}}};
      end else if (w_unf) begin
         w_res_z = {sign_q, {(W-1){1'b0}}};
      end else begin
         w_res_z = {sign_q, w_er[e_p-1:0], w_mr[m_p-1:0]};
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      div_d   = div_q;
      quo_d   = quo_q;
      exp_d   = exp_q;
      sign_d  = sign_q;
      z_d     = z_q;
      inv_d   = inv_q;
      dbz_d   = dbz_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      uni_d   = uni_q;
      case (state_q)
         S_IDLE: begin
            if (v_i) begin
               sign_d = w_sgn;
               if (w_spec) begin
                  z_d     = w_spec_z;
                  inv_d   = w_spec_inv;
                  dbz_d   = w_spec_dbz;
                  uni_d   = w_spec_uni;
                  ovf_d   = 1'b0;
                  unf_d   = 1'b0;
                  state_d = S_DONE;
               end else begin
                  rem_d   = {1'b0, 1'b1, w_ma};
                  div_d   = {1'b1, w_mb};
                  quo_d   = '0;
                  exp_d   = $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + BIAS_S;
                  cnt_d   = CNT_INIT;
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            rem_d = w_rem_nx;
            quo_d = w_quo_nx;
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == '0) begin
               z_d     = w_res_z;
               inv_d   = 1'b0;
               dbz_d   = 1'b0;
               uni_d   = 1'b0;
               ovf_d   = w_ovf;
               unf_d   = w_unf;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (yumi_i) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         div_q   <= '0;
         quo_q   <= '0;
         exp_q   <= '0;
         sign_q  <= 1'b0;
         z_q     <= '0;
         inv_q   <= 1'b0;
         dbz_q   <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         uni_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         div_q   <= div_d;
         quo_q   <= quo_d;
         exp_q   <= exp_d;
         sign_q  <= sign_d;
         z_q     <= z_d;
         inv_q   <= inv_d;
         dbz_q   <= dbz_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
         uni_q   <= uni_d;
      end
   end

   assign ready_and_o      = (state_q == S_IDLE);
   assign v_o              = (state_q == S_DONE);
   assign z_o              = z_q;
   assign invalid_o        = inv_q;
   assign divide_by_zero_o = dbz_q;
   assign overflow_o       = ovf_q;
   assign underflow_o      = unf_q;
   assign unimplemented_o  = uni_q;

endmodule
`default_nettype wire

// File: tb/tb_fpu_div_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fpu_div_seq                                                           |
// | Directed self-checking bench for the single-precision divider.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fpu_div_seq;

`ifdef FPU_DIV_RADIX4_EN
   localparam int LAT_N = 14;
`else
   localparam int LAT_N = 27;
`endif

   // flag vector order: {invalid, divide_by_zero, overflow, underflow, unimplemented}
   localparam logic [4:0] F_NONE = 5'b00000;
   localparam logic [4:0] F_INV  = 5'b10000;
   localparam logic [4:0] F_DBZ  = 5'b01000;
   localparam logic [4:0] F_OVF  = 5'b00100;
   localparam logic [4:0] F_UNF  = 5'b00010;
   localparam logic [4:0] F_UNI  = 5'b00001;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] z;
      logic [4:0]  f;
      logic [7:0]  lat;
   } vec_t;

   logic        clk_i = 1'b0;
   logic        reset_i = 1'b1;
   logic        v_i = 1'b0;
   logic [31:0] a_i = '0;
   logic [31:0] b_i = '0;
   logic        yumi_i = 1'b0;
   logic        ready_and_o, v_o;
   logic [31:0] z_o;
   logic        unimplemented_o, invalid_o, overflow_o, underflow_o, divide_by_zero_o;
   logic [4:0]  flags;

   int total = 0;
   int bad   = 0;

   assign flags = {invalid_o, divide_by_zero_o, overflow_o, underflow_o, unimplemented_o};

   always #5 clk_i = ~clk_i;

   fpu_div_seq #(.e_p(8), .m_p(23)) dut (
      .clk_i            (clk_i),
      .reset_i          (reset_i),
      .v_i              (v_i),
      .a_i              (a_i),
      .b_i              (b_i),
      .ready_and_o      (ready_and_o),
      .v_o              (v_o),
      .z_o              (z_o),
      .unimplemented_o  (unimplemented_o),
      .invalid_o        (invalid_o),
      .overflow_o       (overflow_o),
      .underflow_o      (underflow_o),
      .divide_by_zero_o (divide_by_zero_o),
      .yumi_i           (yumi_i)
   );

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Issue one operation, then step until v_o; lat counts cycles after the accept edge
   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         output int lat, output bit rdy_seen);
      int g = 0;
      while (!ready_and_o && g < 50) begin
         tick();
         g++;
      end
      v_i = 1'b1;
      a_i = a;
      b_i = b;
      tick();
      v_i = 1'b0;
      lat = 1;
      rdy_seen = 1'b0;
      while (!v_o && lat < 100) begin
         if (ready_and_o) rdy_seen = 1'b1;
         tick();
         lat++;
      end
   endtask

   task automatic retire();
      yumi_i = 1'b1;
      tick();
      yumi_i = 1'b0;
   endtask

   task automatic test_reset();
      reset_i = 1'b1;
      repeat (3) tick();
      reset_i = 1'b0;
      total++; if (v_o !== 1'b0) begin bad++; $display("FAIL reset_v_o got=%b want=0", v_o); end
      total++; if (ready_and_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ready_and_o); end
      total++; if (z_o !== 32'h0) begin bad++; $display("FAIL reset_z got=%h want=00000000", z_o); end
      total++; if (flags !== F_NONE) begin bad++; $display("FAIL reset_flags got=%b want=%b", flags, F_NONE); end
   endtask

   task automatic test_normal();
      vec_t tv [6];
      int   lat;
      bit   rdy;
      tv[0] = '{32'h40C00000, 32'h40000000, 32'h40400000, F_NONE, 8'(LAT_N)};
      tv[1] = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, F_NONE, 8'(LAT_N)};
      tv[2] = '{32'h40000000, 32'h3F800000, 32'h40000000, F_NONE, 8'(LAT_N)};
      tv[3] = '{32'hC0C00000, 32'h40000000, 32'hC0400000, F_NONE, 8'(LAT_N)};
      tv[4] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, F_NONE, 8'(LAT_N)};
      tv[5] = '{32'h41200000, 32'hC0800000, 32'hC0200000, F_NONE, 8'(LAT_N)};
      for (int i = 0; i < 6; i++) begin
         run_op(tv[i].a, tv[i].b, lat, rdy);
         total++; if (z_o !== tv[i].z) begin bad++; $display("FAIL normal%0d_z got=%h want=%h", i, z_o, tv[i].z); end
         total++; if (flags !== tv[i].f) begin bad++; $display("FAIL normal%0d_flags got=%b want=%b", i, flags, tv[i].f); end
         total++; if (lat !== int'(tv[i].lat)) begin bad++; $display("FAIL normal%0d_latency got=%0d want=%0d", i, lat, tv[i].lat); end
         total++; if (rdy !== 1'b0) begin bad++; $display("FAIL normal%0d_ready_in_calc got=%b want=0", i, rdy); end
         retire();
      end
   endtask

   task automatic test_specials();
      vec_t tv [10];
      int   lat;
      bit   rdy;
      tv[0] = '{32'h3F800000, 32'h00000000, 32'h7F800000, F_DBZ,  8'd1};
      tv[1] = '{32'h00000000, 32'h00000000, 32'h7FC00000, F_INV,  8'd1};
      tv[2] = '{32'hFF800000, 32'h40000000, 32'hFF800000, F_NONE, 8'd1};
      tv[3] = '{32'h40000000, 32'hFF800000, 32'h80000000, F_NONE, 8'd1};
      tv[4] = '{32'h80000000, 32'h40000000, 32'h80000000, F_NONE, 8'd1};
      tv[5] = '{32'h7F800000, 32'h00000000, 32'h7F800000, F_NONE, 8'd1};
      tv[6] = '{32'h7FC12345, 32'h3F800000, 32'h7FC00000, F_NONE, 8'd1};
      tv[7] = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, F_INV,  8'd1};
      tv[8] = '{32'hBF800000, 32'h80000000, 32'h7F800000, F_DBZ,  8'd1};
      tv[9] = '{32'h00400000, 32'h3F800000, 32'h7FC00000, F_UNI,  8'd1};
      for (int i = 0; i < 10; i++) begin
         run_op(tv[i].a, tv[i].b, lat, rdy);
         total++; if (z_o !== tv[i].z) begin bad++; $display("FAIL special%0d_z got=%h want=%h", i, z_o, tv[i].z); end
         total++; if (flags !== tv[i].f) begin bad++; $display("FAIL special%0d_flags got=%b want=%b", i, flags, tv[i].f); end
         total++; if (lat !== int'(tv[i].lat)) begin bad++; $display("FAIL special%0d_latency got=%0d want=%0d", i, lat, tv[i].lat); end
         retire();
      end
      // Signalling NaN input: result must itself be a signalling NaN
      run_op(32'h7F800001, 32'h3F800000, lat, rdy);
      total++;
      if (!(z_o[30:23] === 8'hFF && z_o[22] === 1'b0 && z_o[21:0] !== 22'h0)) begin
         bad++; $display("FAIL snan_z got=%h want=signalling NaN", z_o);
      end
      total++; if (flags !== F_INV) begin bad++; $display("FAIL snan_flags got=%b want=%b", flags, F_INV); end
      total++; if (lat !== 1) begin bad++; $display("FAIL snan_latency got=%0d want=1", lat); end
      retire();
   endtask

   task automatic test_range();
      vec_t tv [3];
      int   lat;
      bit   rdy;
      tv[0] = '{32'h7F000000, 32'h3E800000, 32'h7F800000, F_OVF, 8'(LAT_N)};
      tv[1] = '{32'h00800000, 32'h40000000, 32'h00000000, F_UNF, 8'(LAT_N)};
      tv[2] = '{32'h80800000, 32'h40000000, 32'h80000000, F_UNF, 8'(LAT_N)};
      for (int i = 0; i < 3; i++) begin
         run_op(tv[i].a, tv[i].b, lat, rdy);
         total++; if (z_o !== tv[i].z) begin bad++; $display("FAIL range%0d_z got=%h want=%h", i, z_o, tv[i].z); end
         total++; if (flags !== tv[i].f) begin bad++; $display("FAIL range%0d_flags got=%b want=%b", i, flags, tv[i].f); end
         total++; if (lat !== int'(tv[i].lat)) begin bad++; $display("FAIL range%0d_latency got=%0d want=%0d", i, lat, tv[i].lat); end
         retire();
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      bit rdy;
      run_op(32'h40C00000, 32'h40000000, lat, rdy);
      total++; if (lat !== LAT_N) begin bad++; $display("FAIL bp_first_latency got=%0d want=%0d", lat, LAT_N); end
      // Offer a new operation while the result is held; it must be ignored until retire
      v_i = 1'b1;
      a_i = 32'h3F800000;
      b_i = 32'h40400000;
      for (int c = 0; c < 10; c++) begin
         tick();
         total++;
         if ({z_o, flags} !== {32'h40400000, F_NONE}) begin
            bad++; $display("FAIL bp_hold%0d_result got=%h/%b want=40400000/%b", c, z_o, flags, F_NONE);
         end
         total++;
         if ({v_o, ready_and_o} !== 2'b10) begin
            bad++; $display("FAIL bp_hold%0d_handshake got v/rdy=%b want=10", c, {v_o, ready_and_o});
         end
      end
      yumi_i = 1'b1;
      tick();
      yumi_i = 1'b0;
      total++;
      if ({v_o, ready_and_o} !== 2'b01) begin
         bad++; $display("FAIL bp_after_yumi got v/rdy=%b want=01", {v_o, ready_and_o});
      end
      tick();
      v_i = 1'b0;
      total++;
      if (ready_and_o !== 1'b0) begin
         bad++; $display("FAIL bp_next_accept got ready=%b want=0", ready_and_o);
      end
      lat = 1;
      while (!v_o && lat < 100) begin
         tick();
         lat++;
      end
      total++; if (lat !== LAT_N) begin bad++; $display("FAIL bp_second_latency got=%0d want=%0d", lat, LAT_N); end
      total++; if (z_o !== 32'h3EAAAAAB) begin bad++; $display("FAIL bp_second_z got=%h want=3EAAAAAB", z_o); end
      retire();
   endtask

   task automatic test_reset_mid_calc();
      int lat;
      bit rdy;
      bit seen = 1'b0;
      v_i = 1'b1;
      a_i = 32'h40C00000;
      b_i = 32'h40000000;
      tick();
      v_i = 1'b0;
      repeat (4) tick();
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      total++; if (v_o !== 1'b0) begin bad++; $display("FAIL abort_v_o got=%b want=0", v_o); end
      total++; if (ready_and_o !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b want=1", ready_and_o); end
      total++; if (z_o !== 32'h0) begin bad++; $display("FAIL abort_z got=%h want=00000000", z_o); end
      repeat (30) begin
         if (v_o) seen = 1'b1;
         tick();
      end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_pulse got=%b want=0", seen); end
      run_op(32'h40C00000, 32'h40000000, lat, rdy);
      total++; if (z_o !== 32'h40400000) begin bad++; $display("FAIL abort_fresh_z got=%h want=40400000", z_o); end
      total++; if (lat !== LAT_N) begin bad++; $display("FAIL abort_fresh_latency got=%0d want=%0d", lat, LAT_N); end
      retire();
   endtask

   initial begin
      test_reset();
      test_normal();
      test_specials();
      test_range();
      test_back_to_back();
      test_reset_mid_calc();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout want=completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
